dmem_line_adapter: RTL
======================

Name: dmem_line_adapter

Overview:
- Responder for the CPU data-memory port; services the word-level requests the MEM stage issues.
- The MEM stage drives dmem_address/dmem_read/dmem_write/mem_byte_enable/dmem_wdata; this block returns dmem_rdata/dmem_resp.
- Holds one line buffer and converts misses into whole-line reads and write-backs on the physical-memory line interface.
- Sits between the cpu top and the pmem arbiter.

Parameters:
LINE_BITS, 256, line width in bits; must be 32*2^k with k≥1; OFF_BITS = log2(LINE_BITS/8), WIDX_BITS = OFF_BITS-2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dmem_address  in  32  byte address; bits [1:0] ignored
dmem_read  in  1  read request; held until dmem_resp
dmem_write  in  1  write request; held until dmem_resp
mem_byte_enable  in  4  write byte mask, bit i -> dmem_wdata[8i+7:8i]
dmem_wdata  in  32  write data
dmem_rdata  out  32  read data, valid when dmem_resp=1
dmem_resp  out  1  single-cycle completion pulse
pmem_address  out  32  line address, low OFF_BITS bits zero
pmem_read  out  1  line read request; held until pmem_resp
pmem_write  out  1  line write request; held until pmem_resp
pmem_wdata  out  LINE_BITS  line write data
pmem_rdata  in  LINE_BITS  line read data, valid with pmem_resp
pmem_resp  in  1  line transfer complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- State: valid, dirty, tag[31:OFF_BITS], line[LINE_BITS-1:0]; word index w = dmem_address[OFF_BITS-1:2].
- FSM states: IDLE, RESP, WB, FILL. Reset enters IDLE and clears valid and dirty. Line contents are don't-care after reset.
- Output values at reset and in IDLE: dmem_resp=0, pmem_read=0, pmem_write=0, dmem_rdata=0, pmem_address=0.
- req = dmem_read | dmem_write. hit = valid & (tag == dmem_address[31:OFF_BITS]).
- IDLE transitions:
  - no req: stay in IDLE.
  - req & hit: go to RESP. On a write, merge enabled bytes into word w, and set dirty if mem_byte_enable≠0.
  - req & !hit & valid & dirty: go to WB.
  - otherwise (req & !hit): go to FILL.
- WB:
  - Drive pmem_write=1, pmem_address={tag,0s}, pmem_wdata=line; all are registered and stable until pmem_resp.
  - On pmem_resp: clear dirty, go to FILL.
- FILL:
  - Drive pmem_read=1, pmem_address={dmem_address[31:OFF_BITS],0s}.
  - On pmem_resp: line<=pmem_rdata, tag<=request tag, valid<=1, go to IDLE. The access then re-evaluates as a hit.
- RESP: one cycle only.
  - dmem_resp=1, dmem_rdata=line word w after any merge. A write returns the merged word.
  - Next state is always IDLE.
- Latency:
  - Hit: dmem_resp is seen 1 cycle after the request is first sampled in IDLE.
  - Clean miss: fill time + 2 cycles.
  - Dirty miss: write-back time + fill time + 2 cycles.
- Request rules:
  - Request inputs are sampled only in IDLE.
  - The initiator may present a new request in the cycle after dmem_resp; that cycle is IDLE and samples it.
- dmem_read & dmem_write both high: the request is a write. dmem_rdata returns the merged word.
- Write with mem_byte_enable=0000: completes like a hit or miss, and dirty is not set by it.
- pmem_resp while not in WB or FILL: ignored.
- rst mid-transaction: in the next cycle the FSM is in IDLE, pmem_read=pmem_write=0, valid=0, dirty=0. The in-flight request is dropped and no dmem_resp is issued.
- Wrap-around: the highest line address 0xFFFFFFE0 (for LINE_BITS=256) behaves like any other line.

Optional Feature:
- Macro: DMEM_LINE_ADAPTER_PERF_EN.
- When defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments when IDLE sees req & hit on the first sampling cycle of a request.
  - miss_count increments on each IDLE -> WB or IDLE -> FILL transition.
  - The hit after a fill is not counted. Both counters saturate at 0xFFFFFFFF.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then read 0x00000104 with pmem returning a line whose word1=0xDEADBEEF after 3 cycles -> pmem_read with pmem_address=0x00000100; dmem_resp with dmem_rdata=0xDEADBEEF; one pulse only.
- Same line: write 0x00000108, mem_byte_enable=0010, dmem_wdata=0x0000AB00 -> dmem_resp 1 cycle after sampling. A following read of 0x00000108 returns the old word with byte1 replaced by 0xAB.
- Then read 0x00000200 -> pmem_write first with pmem_address=0x00000100 and pmem_wdata containing the merged word. pmem_read of 0x00000200 follows; no pmem_write on a later clean miss.
- Write with mem_byte_enable=0000 to a clean resident line, then a miss to another line -> no pmem_write issued.
- Assert rst while pmem_read is high, then raise pmem_resp -> pmem_read=0 the cycle after rst, no dmem_resp, and the next read of the same address misses again.
- PERF_EN build, sequence miss/hit/hit/miss -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/dmem_line_adapter.sv
// Purpose : single-line buffer between the CPU data port and the pmem line interface.
// Latency : hit 1 cycle after sampling; clean miss fill+2; dirty miss write-back+fill+2.
// Backpr. : requests are held by the initiator until dmem_resp; pmem requests are held until pmem_resp.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   dmem_address/read/write      word request from the MEM stage (held until dmem_resp)
//   mem_byte_enable, dmem_wdata  write byte mask and write data
//   dmem_rdata, dmem_resp        read/merged data and one-cycle completion pulse
//   pmem_address/read/write      line address and line requests (held until pmem_resp)
//   pmem_wdata, pmem_rdata       whole-line write-back and fill data
//   pmem_resp                    line transfer complete
//   hit_count, miss_count        saturating counters, present only with DMEM_LINE_ADAPTER_PERF_EN
//
// Optional feature macro: DMEM_LINE_ADAPTER_PERF_EN (adds hit/miss counters).

module dmem_line_adapter #(
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dmem_address,
  input  logic                 dmem_read,
  input  logic                 dmem_write,
  input  logic [3:0]           mem_byte_enable,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output logic                 dmem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef DMEM_LINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
  localparam int WIDX_BITS = OFF_BITS - 2;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int TAG_BITS  = 32 - OFF_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    WB   = 2'd2,
    FILL = 2'd3
  } state_t;

  // Buffer state
  state_t                     state_q, state_d;
  logic                       valid_q, valid_d;
  logic                       dirty_q, dirty_d;
  logic [TAG_BITS-1:0]        tag_q, tag_d;
  logic [WORDS-1:0][31:0]     line_q, line_d;

  // Registered outputs
  logic                       dmem_resp_q, dmem_resp_d;
  logic [31:0]                dmem_rdata_q, dmem_rdata_d;
  logic                       pmem_read_q, pmem_read_d;
  logic                       pmem_write_q, pmem_write_d;
  logic [31:0]                pmem_address_q, pmem_address_d;
  logic [LINE_BITS-1:0]       pmem_wdata_q, pmem_wdata_d;

  // Request decode
  logic [TAG_BITS-1:0]        req_tag;
  logic [WIDX_BITS-1:0]       widx;
  logic                       req;
  logic                       hit;
  logic [31:0]                cur_word;
  logic [31:0]                merged_word;

  assign req_tag  = dmem_address[31:OFF_BITS];
  assign widx     = dmem_address[OFF_BITS-1:2];
  assign req      = dmem_read | dmem_write;
  assign hit      = valid_q && (tag_q == req_tag);
  assign cur_word = line_q[widx];

  // Byte-address bits below the word are not used by this block.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^dmem_address[1:0];

  // Write data merged into the addressed word; only meaningful on a write hit.
  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        merged_word[b*8 +: 8] = dmem_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    line_d         = line_q;
    dmem_resp_d    = 1'b0;
    dmem_rdata_d   = '0;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = '0;
    pmem_wdata_d   = pmem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_d     = RESP;
            dmem_resp_d = 1'b1;
            // A simultaneous read+write is treated as a write.
            if (dmem_write) begin
              line_d[widx] = merged_word;
              dmem_rdata_d = merged_word;
              if (mem_byte_enable != 4'b0000) begin
                dirty_d = 1'b1;
              end
            end else begin
              dmem_rdata_d = cur_word;
            end
          end else if (valid_q && dirty_q) begin
            state_d        = WB;
            pmem_write_d   = 1'b1;
            pmem_address_d = {tag_q, {OFF_BITS{1'b0}}};
            pmem_wdata_d   = line_q;
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag, {OFF_BITS{1'b0}}};
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      WB: begin
        if (pmem_resp) begin
          dirty_d        = 1'b0;
          state_d        = FILL;
          pmem_read_d    = 1'b1;
          pmem_address_d = {req_tag, {OFF_BITS{1'b0}}};
        end else begin
          pmem_write_d   = 1'b1;
          pmem_address_d = pmem_address_q;
        end
      end

      FILL: begin
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          // The fill address register already holds the requested tag.
          tag_d   = pmem_address_q[31:OFF_BITS];
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          pmem_read_d    = 1'b1;
          pmem_address_d = pmem_address_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DMEM_LINE_ADAPTER_PERF_EN
  // refill_q marks the IDLE re-evaluation that directly follows a fill, so the
  // resulting hit belongs to the miss already counted and is not counted again.
  logic        refill_q, refill_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    refill_d     = refill_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req) begin
      refill_d = 1'b0;
      if (hit) begin
        if (!refill_q && hit_count_q != 32'hFFFF_FFFF) begin
          hit_count_d = hit_count_q + 32'd1;
        end
      end else if (miss_count_q != 32'hFFFF_FFFF) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
    if (state_q == FILL && pmem_resp) begin
      refill_d = 1'b1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  always_ff @(posedge clk) begin
    // Line data, tag and write-back data carry no reset value; valid gates their use.
    line_q       <= line_d;
    tag_q        <= tag_d;
    pmem_wdata_q <= pmem_wdata_d;
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= 1'b0;
      dirty_q        <= 1'b0;
      dmem_resp_q    <= 1'b0;
      dmem_rdata_q   <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
`ifdef DMEM_LINE_ADAPTER_PERF_EN
      refill_q       <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      dmem_resp_q    <= dmem_resp_d;
      dmem_rdata_q   <= dmem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
`ifdef DMEM_LINE_ADAPTER_PERF_EN
      refill_q       <= refill_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
`endif
    end
  end

  assign dmem_resp    = dmem_resp_q;
  assign dmem_rdata   = dmem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule
